// File: rtl/c_bus_writer_pkg.sv
// c_bus_writer_pkg: shared processor constants (bus select codes, widths, inc_ctrl bit indices)
package c_bus_writer_pkg;
  localparam int DW = 16;
  localparam int BW = 8;
  localparam int NDEST = 9;
  localparam logic [3:0] SEL_MDR = 4'd1;
  localparam logic [3:0] SEL_PC  = 4'd2;
  localparam logic [3:0] SEL_MAR = 4'd3;
  localparam logic [3:0] SEL_L   = 4'd4;
  localparam logic [3:0] SEL_C1  = 4'd5;
  localparam logic [3:0] SEL_C2  = 4'd6;
  localparam logic [3:0] SEL_C3  = 4'd7;
  localparam logic [3:0] SEL_T   = 4'd8;
  localparam logic [3:0] SEL_E   = 4'd9;
  localparam int W_MDR = 0;
  localparam int W_PC  = 1;
  localparam int W_MAR = 2;
  localparam int W_L   = 3;
  localparam int W_C1  = 4;
  localparam int W_C2  = 5;
  localparam int W_C3  = 6;
  localparam int W_T   = 7;
  localparam int W_E   = 8;
  localparam int INC_PC = 0;
  localparam int INC_C1 = 1;
  localparam int INC_C2 = 2;
  localparam int INC_C3 = 3;
endpackage

// File: rtl/dest_decoder.sv
// dest_decoder: C-bus select code to one-hot write enable; bit index is code - SEL_MDR
module dest_decoder
  import c_bus_writer_pkg::*;
(
  input  logic [3:0]       code,
  output logic [NDEST-1:0] we
);
  always_comb we = (code >= SEL_MDR && code <= SEL_E) ? NDEST'(1) << (code - SEL_MDR) : '0;
endmodule

// File: rtl/c_bus_writer.sv
// c_bus_writer: C-bus write-back register file; counter increments enabled by macro C_BUS_INC_EN
module c_bus_writer
  import c_bus_writer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] C_Bus,
  input  logic [3:0]    C_Bus_ctrl,
  input  logic [3:0]    inc_ctrl,
  output logic [DW-1:0] L,
  output logic [DW-1:0] C1,
  output logic [DW-1:0] C2,
  output logic [DW-1:0] C3,
  output logic [DW-1:0] T,
  output logic [DW-1:0] E,
  output logic [BW-1:0] PC,
  output logic [BW-1:0] MDR,
  output logic [BW-1:0] MAR,
  output logic          Z,
  output logic          wr_valid
);
  logic [NDEST-1:0] we;
  logic [3:0] inc;
  logic is_byte, z_next;
  dest_decoder u_dec (.code(C_Bus_ctrl), .we(we));
`ifdef C_BUS_INC_EN
  assign inc = inc_ctrl;
`else
  logic unused_inc;
  assign unused_inc = ^inc_ctrl;
  assign inc = '0;
`endif
  // Z reflects the value actually stored, so byte destinations test only the low byte
  assign is_byte = we[W_MDR] | we[W_PC] | we[W_MAR];
  assign z_next = is_byte ? C_Bus[BW-1:0] == '0 : C_Bus == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {L, C1, C2, C3, T, E} <= '0;
      {PC, MDR, MAR} <= '0;
      Z <= 1'b0;
      wr_valid <= 1'b0;
    end else begin
      if (we[W_MDR]) MDR <= C_Bus[BW-1:0];
      if (we[W_MAR]) MAR <= C_Bus[BW-1:0];
      if (we[W_L]) L <= C_Bus;
      if (we[W_T]) T <= C_Bus;
      if (we[W_E]) E <= C_Bus;
      if (we[W_PC]) PC <= C_Bus[BW-1:0];
      else if (inc[INC_PC]) PC <= PC + 8'd1;
      if (we[W_C1]) C1 <= C_Bus;
      else if (inc[INC_C1]) C1 <= C1 + 16'd1;
      if (we[W_C2]) C2 <= C_Bus;
      else if (inc[INC_C2]) C2 <= C2 + 16'd1;
      if (we[W_C3]) C3 <= C_Bus;
      else if (inc[INC_C3]) C3 <= C3 + 16'd1;
      if (|we) Z <= z_next;
      wr_valid <= |we;
    end
  end
endmodule

// File: tb/tb_c_bus_writer.sv
// tb_c_bus_writer: table vectors, corner sequences and random stimulus vs a register-array model
module tb_c_bus_writer;
`ifdef C_BUS_INC_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif
  localparam int TGT [4] = '{1, 4, 5, 6};
  localparam string NM [9] = '{"MDR", "PC", "MAR", "L", "C1", "C2", "C3", "T", "E"};
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] C_Bus = '0;
  logic [3:0] C_Bus_ctrl = '0, inc_ctrl = '0;
  logic [15:0] L, C1, C2, C3, T, E;
  logic [7:0] PC, MDR, MAR;
  logic Z, wr_valid;
  logic [15:0] dv [9];
  logic [15:0] m [9];
  logic mz = 1'b0, mwv = 1'b0;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [3:0] ctrl;
    logic [15:0] data;
    int reg_idx;
    logic [15:0] exp_val;
    logic exp_z;
    logic exp_wv;
  } vec_t;
  vec_t vt [8];
  c_bus_writer dut (
    .clk(clk), .rst_n(rst_n), .C_Bus(C_Bus), .C_Bus_ctrl(C_Bus_ctrl), .inc_ctrl(inc_ctrl),
    .L(L), .C1(C1), .C2(C2), .C3(C3), .T(T), .E(E), .PC(PC), .MDR(MDR), .MAR(MAR),
    .Z(Z), .wr_valid(wr_valid)
  );
  always #5 clk = ~clk;
  assign dv[0] = {8'h00, MDR};
  assign dv[1] = {8'h00, PC};
  assign dv[2] = {8'h00, MAR};
  assign dv[3] = L;
  assign dv[4] = C1;
  assign dv[5] = C2;
  assign dv[6] = C3;
  assign dv[7] = T;
  assign dv[8] = E;
  function automatic logic [15:0] wmask(int i);
    return (i <= 2) ? 16'h00FF : 16'hFFFF;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 9; i++) m[i] = '0;
    mz = 1'b0;
    mwv = 1'b0;
  endtask
  task automatic model_step(logic [3:0] c, logic [15:0] d, logic [3:0] inc);
    logic [15:0] nx [9];
    int w;
    w = (c >= 1 && c <= 9) ? int'(c) - 1 : -1;
    nx = m;
    if (INC_EN)
      for (int b = 0; b < 4; b++)
        if (inc[b]) nx[TGT[b]] = 16'((32'(m[TGT[b]]) + 1) & 32'(wmask(TGT[b])));
    if (w >= 0) begin
      nx[w] = d & wmask(w);
      mz = (nx[w] == 0);
    end
    mwv = (w >= 0);
    m = nx;
  endtask
  task automatic chk(string n, logic [15:0] a, logic [15:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic check_all(string tag);
    for (int i = 0; i < 9; i++) chk({tag, ".", NM[i]}, dv[i], m[i]);
    chk({tag, ".Z"}, 16'(Z), 16'(mz));
    chk({tag, ".wr_valid"}, 16'(wr_valid), 16'(mwv));
  endtask
  task automatic step(logic [3:0] c, logic [15:0] d, logic [3:0] i);
    C_Bus_ctrl = c;
    C_Bus = d;
    inc_ctrl = i;
    @(posedge clk);
    #1;
    model_step(c, d, i);
  endtask
  initial begin
    vt[0] = '{4'h4, 16'h1234, 3, 16'h1234, 1'b0, 1'b1};
    vt[1] = '{4'h2, 16'hAB00, 1, 16'h0000, 1'b1, 1'b1};
    vt[2] = '{4'hB, 16'hFFFF, -1, 16'h0000, 1'b1, 1'b0};
    vt[3] = '{4'h1, 16'hBEEF, 0, 16'h00EF, 1'b0, 1'b1};
    vt[4] = '{4'h9, 16'h0000, 8, 16'h0000, 1'b1, 1'b1};
    vt[5] = '{4'h5, 16'hFFFF, 4, 16'hFFFF, 1'b0, 1'b1};
    vt[6] = '{4'h2, 16'h00FF, 1, 16'h00FF, 1'b0, 1'b1};
    vt[7] = '{4'h0, 16'h1200, -1, 16'h0000, 1'b0, 1'b0};
    model_reset();
    #1;
    check_all("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(vt[k].ctrl, vt[k].data, 4'h0);
      if (vt[k].reg_idx >= 0) chk($sformatf("vec%0d.%s", k, NM[vt[k].reg_idx]), dv[vt[k].reg_idx], vt[k].exp_val);
      chk($sformatf("vec%0d.Z", k), 16'(Z), 16'(vt[k].exp_z));
      chk($sformatf("vec%0d.wr_valid", k), 16'(wr_valid), 16'(vt[k].exp_wv));
      check_all($sformatf("vec%0d", k));
    end
    step(4'h0, 16'h0000, 4'b0010);
    chk("c1_wrap", C1, INC_EN ? 16'h0000 : 16'hFFFF);
    chk("c1_wrap.Z", 16'(Z), 16'(1'b0));
    step(4'h0, 16'h0000, 4'b0001);
    chk("pc_wrap", 16'(PC), INC_EN ? 16'h0000 : 16'h00FF);
    step(4'h6, 16'h0005, 4'b0110);
    chk("wr_beats_inc.C2", C2, 16'h0005);
    chk("wr_beats_inc.C1", C1, INC_EN ? 16'h0001 : 16'hFFFF);
    check_all("wr_beats_inc");
    for (int k = 0; k < 4; k++) step(4'h0, 16'hFFFF, 4'b1111);
    check_all("inc_all");
    step(4'h4, 16'hA5A5, 4'h0);
    C_Bus_ctrl = 4'h4;
    C_Bus = 16'h5555;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    @(posedge clk);
    #1;
    check_all("reset_held");
    rst_n = 1'b1;
    #2;
    check_all("release");
    @(posedge clk);
    #1;
    model_step(4'h4, 16'h5555, 4'h0);
    check_all("first_edge");
    for (int k = 0; k < 400; k++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 5) == 0) ? 16'h0000 : ($urandom_range(0, 3) == 0) ? 16'(($urandom_range(0, 1)) << 8) : 16'($urandom);
      step(4'($urandom_range(0, 15)), d, 4'($urandom));
      check_all($sformatf("rnd%0d", k));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
